// File: rtl/circ335_pkg.sv
// Shared definitions for the circ335 exerciser: state encodings, vector count
// and the golden {D,E} function of the circ335 circuit.
package circ335_pkg;

    localparam int unsigned NUM_VEC = 8;
    localparam int unsigned VEC_W   = 3;
    localparam int unsigned ERR_W   = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPLY  = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    // idx is {A,B,C} with A as the MSB; result is {D,E}
    function automatic logic [1:0] exp_de(input logic [VEC_W-1:0] idx);
        return {(idx[2] & idx[1]) | ~idx[0], ~idx[0]};
    endfunction

endpackage

// File: rtl/circ335_golden.sv
// Combinational reference model of circ335: D = (A&B) | ~C, E = ~C.
module circ335_golden
    import circ335_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic c,
    output logic d,
    output logic e
);

    assign {d, e} = exp_de({a, b, c});

endmodule

// File: rtl/circ335_exerciser.sv
// Walks all 8 input vectors through circ335, waits a settle window, checks {D,E}.
// Optional settle-time measurement is enabled with `define CIRC335_SETTLE_MEAS_EN.
module circ335_exerciser
    import circ335_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 6,
    parameter int unsigned SW            = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          a_o,
    output logic          b_o,
    output logic          c_o,
    input  logic          d_i,
    input  logic          e_i,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [3:0]    err_count,
    output logic [7:0]    fail_vec,
    output logic [SW-1:0] max_settle
);

    localparam int unsigned   SETTLE_EFF = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
    localparam logic [SW-1:0] SETTLE_LD  = SW'(SETTLE_EFF);

    state_t              state_q, state_d;
    logic [VEC_W-1:0]    idx_q, idx_d;
    logic [SW-1:0]       cnt_q, cnt_d;
    logic [VEC_W-1:0]    abc_q, abc_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic [NUM_VEC-1:0]  fail_q, fail_d;
    logic                exp_d_c, exp_e_c;

    circ335_golden u_golden (
        .a (idx_q[2]),
        .b (idx_q[1]),
        .c (idx_q[0]),
        .d (exp_d_c),
        .e (exp_e_c)
    );

    // State and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            abc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            abc_q   <= abc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        abc_d   = abc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        fail_d  = fail_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    err_d   = '0;
                    fail_d  = '0;
                    pass_d  = 1'b0;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = APPLY;
                end
            end
            APPLY: begin
                abc_d   = idx_q;
                cnt_d   = SETTLE_LD;
                state_d = SETTLE;
            end
            SETTLE: begin
                if (cnt_q <= SW'(1)) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q - SW'(1);
                end
            end
            SAMPLE: begin
                if ({d_i, e_i} != {exp_d_c, exp_e_c}) begin
                    fail_d[idx_q] = 1'b1;
                    err_d         = err_q + ERR_W'(1);
                end
                if (idx_q == VEC_W'(NUM_VEC - 1)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + VEC_W'(1);
                    state_d = APPLY;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign {a_o, b_o, c_o} = abc_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign fail_vec        = fail_q;

`ifdef CIRC335_SETTLE_MEAS_EN
    logic [SW-1:0] t_q;
    logic [SW-1:0] max_q;
    logic [1:0]    prev_de_q;

    // t counts SETTLE cycles from 1; record t whenever {D,E} moved since the last edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            t_q       <= '0;
            max_q     <= '0;
            prev_de_q <= '0;
        end else begin
            prev_de_q <= {d_i, e_i};
            if (state_q == IDLE && start) begin
                max_q <= '0;
            end else if (state_q == SETTLE && {d_i, e_i} != prev_de_q && t_q > max_q) begin
                max_q <= t_q;
            end
            if (state_q == APPLY) begin
                t_q <= SW'(1);
            end else if (state_q == SETTLE && t_q != '1) begin
                t_q <= t_q + SW'(1);
            end
        end
    end

    assign max_settle = max_q;
`else
    assign max_settle = '0;
`endif

endmodule

// File: doc/circ335_exerciser.md
Name: circ335_exerciser

Overview:
- Sequential stimulus/response driver for the circ335 gate-level circuit (D = (A&B) | ~C, E = ~C).
- Drives inputs A, B, C with all 8 vectors in order and waits a programmable settle window so gate propagation delay can elapse.
- Samples D and E, compares them with the golden function, and reports per-vector pass/fail.
- Sits in the lab testbench/board top between a start control and the device under test (DUT).

Parameters:
- SETTLE_CYCLES, 6, clock cycles to wait after applying a vector before sampling. Legal range is 1..15; a value of 0 is treated as 1.
- SW, 4, width of the settle counter and of max_settle.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  begin a run; sampled only in IDLE
- a_o  output  1  DUT input A (registered)
- b_o  output  1  DUT input B (registered)
- c_o  output  1  DUT input C (registered)
- d_i  input  1  DUT output D
- e_i  input  1  DUT output E
- busy  output  1  high from APPLY of vector 0 through SAMPLE of vector 7
- done  output  1  one-cycle pulse at end of run
- pass  output  1  1 when err_count==0; valid while done is high and held until the next start
- err_count  output  4  number of failing vectors, 0..8
- fail_vec  output  8  bit i set if vector i failed
- max_settle  output  SW  measured settle time (see Optional Feature)

Behaviour:
- Reset (rst_n low at a rising edge) forces all outputs to 0 and the state to IDLE, from any state.
  - Reset mid-run aborts the run; no done pulse is produced.
- State machine:
  - IDLE: on start=1, clear err_count, fail_vec and max_settle; set idx=0; go to APPLY.
  - APPLY: {a_o,b_o,c_o} <= idx (A is the MSB); load settle counter with SETTLE_CYCLES; go to SETTLE.
  - SETTLE: decrement the counter; when it reaches 1, go to SAMPLE. This gives exactly SETTLE_CYCLES cycles in SETTLE.
  - SAMPLE: compare {d_i,e_i} with the expected value for idx.
    - On mismatch: set fail_vec[idx] and increment err_count.
    - If idx==7, go to DONE; otherwise idx++ and go to APPLY.
  - DONE: done=1 for exactly one cycle; pass=(err_count==0); go to IDLE.
- Timing and latency:
  - Each vector takes SETTLE_CYCLES+2 cycles.
  - done is high in the cycle after the 8*(SETTLE_CYCLES+2)-th rising edge following the edge that sampled start. With the default this is 64 edges.
- start handling:
  - start while not in IDLE is ignored; runs do not queue.
  - start held high continuously starts a new run on each return to IDLE.
- Output hold:
  - a_o/b_o/c_o hold the last vector (3'b111) after the run.
  - Result outputs hold until the next accepted start or reset.
- d_i and e_i are sampled only in SAMPLE, except for the optional measurement below.

Optional Feature:
- Macro CIRC335_SETTLE_MEAS_EN.
- When defined:
  - Per vector, a timer t is set to 1 at the first SETTLE cycle and increments each SETTLE cycle.
  - Whenever {d_i,e_i} differs from its value at the previous edge, record t.
  - max_settle = the maximum recorded t over all vectors. It saturates at 2^SW-1 and is valid at done.
- When undefined: max_settle is tied to 0 and the timer logic is absent. The port list is identical in both cases.

Decomposition:
- Shared package/include circ335_pkg holds:
  - state encodings (IDLE, APPLY, SETTLE, SAMPLE, DONE) as localparams;
  - NUM_VEC=8;
  - an expected-value function exp_de(idx) returning {D,E}.
- One sub-module: circ335_golden, the combinational reference {D,E} from {A,B,C}. The exerciser and the bench scoreboard share it.

Test Plan:
- Correct DUT, SETTLE_CYCLES=6, pulse start -> done at edge 64, pass=1, err_count=0, fail_vec=8'h00.
- DUT with E stuck at 0 -> err_count=4, fail_vec=8'h55, pass=0.
- DUT with D stuck at 0 -> err_count=5, fail_vec=8'hD5, pass=0.
- start pulsed again at edge 20 of a run -> ignored; a single done at edge 64; results identical to the single-run case.
- rst_n low at edge 30 -> next cycle all outputs 0 and state IDLE; no done; a fresh start then completes normally 64 edges later.
- CIRC335_SETTLE_MEAS_EN defined, DUT behind a 3-register delay line, SETTLE_CYCLES=6 -> max_settle=4, pass=1.
  - Same DUT with SETTLE_CYCLES=2 -> pass=0.
  - With the macro undefined, max_settle=0.
